fifo_sample_serializer: RTL and testbench

Read-side consumer for the sample FIFO that the function generator fills. The block pops one signed sample at a time from the FIFO and shifts it out MSB-first on a 3-wire serial DAC interface (cs_n_o, sclk_o, sdata_o). It inserts an inter-frame gap between samples and flags underruns when the FIFO runs dry during streaming.

---
 rtl/fifo_ser_pkg.sv | 11 +
 rtl/fifo_ser_clkdiv.sv | 50 +++++
 rtl/fifo_sample_serializer.sv | 166 ++++++++++++++++
 tb/tb_fifo_sample_serializer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO sample serializer.
package fifo_ser_pkg;

    typedef enum logic [2:0] {IDLE, REQ, LOAD, SHIFT, GAP} state_e;

    // Wide enough to hold a bit count running from 0 up to and including dw.
    function automatic int unsigned bit_cnt_w(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/fifo_ser_clkdiv.sv
// Serial clock generator: divides clk by 2*CLK_DIV while run_i is high, idles low otherwise.
module fifo_ser_clkdiv #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic sclk_o,
    output logic fall_pulse_o,
    output logic rise_pulse_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             tc;

    assign tc = run_i && (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!run_i) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (tc) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    // Pulses mark the clk edge at which sclk_o is about to change.
    assign fall_pulse_o = tc & sclk_q;
    assign rise_pulse_o = tc & ~sclk_q;
    assign sclk_o       = sclk_q;

endmodule

// File: rtl/fifo_sample_serializer.sv
// Pops samples from the generator FIFO and shifts them MSB-first onto a 3-wire serial DAC bus.
module fifo_sample_serializer
    import fifo_ser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  rd_en_o,
    output logic                  cs_n_o,
    output logic                  sclk_o,
    output logic                  sdata_o,
    output logic                  busy_o,
    output logic                  underrun_o,
    output logic [CNT_W-1:0]      frames_o
);

    localparam int unsigned BCW = bit_cnt_w(DATA_WIDTH);
    localparam int unsigned GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0]        gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]      frames_q, frames_d;
    logic                  last_q, last_d;
    logic                  rd_en_q, rd_en_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sdata_q, sdata_d;
    logic                  busy_q, busy_d;
    logic                  underrun_q, underrun_d;
    logic                  armed_q, armed_d;
    logic                  settle_q, settle_d;
    logic                  sclk, fall_pulse, rise_pulse;

    fifo_ser_clkdiv #(
        .CLK_DIV(CLK_DIV)
    ) u_clkdiv (
        .clk         (clk),
        .rst         (rst),
        .run_i       (state_q == SHIFT),
        .sclk_o      (sclk),
        .fall_pulse_o(fall_pulse),
        .rise_pulse_o(rise_pulse)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        frames_d   = frames_q;
        last_d     = last_q;
        rd_en_d    = 1'b0;
        cs_n_d     = cs_n_q;
        sdata_d    = sdata_q;
        underrun_d = underrun_q;
        armed_d    = armed_q;
        settle_d   = settle_q;

        case (state_q)
            IDLE: begin
                // One quiet IDLE cycle after GAP before a new request is considered.
                if (settle_q) begin
                    settle_d = 1'b0;
                end else if (!en_i) begin
                    armed_d = 1'b0;
                end else if (!empty_i) begin
                    state_d = REQ;
                    rd_en_d = 1'b1;
                end else if (armed_q) begin
                    underrun_d = 1'b1;
                end
            end
            REQ: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d   = data_i;
                sdata_d   = data_i[DATA_WIDTH-1];
                cs_n_d    = 1'b0;
                bit_cnt_d = '0;
                last_d    = 1'b0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                // last_q marks that the DAC has clocked in the LSB.
                if (rise_pulse && bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                    last_d = 1'b1;
                end
                if (fall_pulse) begin
                    shift_d   = shift_q << 1;
                    sdata_d   = shift_d[DATA_WIDTH-1];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_q) begin
                        state_d   = GAP;
                        cs_n_d    = 1'b1;
                        gap_cnt_d = '0;
                        frames_d  = frames_q + 1'b1;
                        armed_d   = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GCW'(GAP_CYCLES - 1)) begin
                    state_d  = IDLE;
                    settle_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            frames_q   <= '0;
            last_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            sdata_q    <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            armed_q    <= 1'b0;
            settle_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            frames_q   <= frames_d;
            last_q     <= last_d;
            rd_en_q    <= rd_en_d;
            cs_n_q     <= cs_n_d;
            sdata_q    <= sdata_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            armed_q    <= armed_d;
            settle_q   <= settle_d;
        end
    end

    assign rd_en_o    = rd_en_q;
    assign cs_n_o     = cs_n_q;
    assign sclk_o     = sclk;
    assign sdata_o    = sdata_q;
    assign busy_o     = busy_q;
    assign underrun_o = underrun_q;
    assign frames_o   = frames_q;

endmodule

// File: tb/tb_fifo_sample_serializer.sv
// Scoreboard bench: FIFO model feeds the DUT, a DAC model captures frames and compares them.
module tb_fifo_sample_serializer;

    localparam int DW    = 8;
    localparam int CD    = 2;
    localparam int GC    = 2;
    localparam int CW    = 2;
    localparam int FRAME = 2 * CD * DW;
    localparam int GAPH  = GC + 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_i = 1'b0;
    logic          empty_i = 1'b1;
    logic [DW-1:0] data_i = '0;
    logic          rd_en_o, cs_n_o, sclk_o, sdata_o, busy_o, underrun_o;
    logic [CW-1:0] frames_o;

    fifo_sample_serializer #(
        .DATA_WIDTH(DW),
        .CLK_DIV   (CD),
        .GAP_CYCLES(GC),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_i),
        .empty_i   (empty_i),
        .data_i    (data_i),
        .rd_en_o   (rd_en_o),
        .cs_n_o    (cs_n_o),
        .sclk_o    (sclk_o),
        .sdata_o   (sdata_o),
        .busy_o    (busy_o),
        .underrun_o(underrun_o),
        .frames_o  (frames_o)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            gaps_q[$];
    int            frames_log[$];
    int            pops = 0;
    int            frames_done = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int target;
        int t;
        target = frames_done + n;
        t = 0;
        while (frames_done < target && t < budget) begin
            cycle(1);
            t++;
        end
        check("frame_timeout", 32'(frames_done >= target), 32'd1);
    endtask

    task automatic wait_cs_low(input int budget);
        int t;
        t = 0;
        while (cs_n_o !== 1'b0 && t < budget) begin
            cycle(1);
            t++;
        end
        check("cs_low_timeout", {31'd0, cs_n_o}, 32'd0);
    endtask

    // FIFO model: data valid one cycle after a pop request.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && rd_en_o) begin
                pops++;
                check("rd_en_nonempty", 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) begin
                    data_i = fifo_q.pop_front();
                    exp_q.push_back(data_i);
                end
            end
            empty_i = (fifo_q.size() == 0);
        end
    end

    // DAC model: samples sdata on sclk rising edges while cs is low.
    initial begin
        logic          prev_cs, prev_sclk, prev_sdata, prev_rst, in_frame, have_rise;
        logic [DW-1:0] word, want;
        int            bits, low_cyc, high_cyc, exp_frames;
        prev_cs = 1'b1; prev_sclk = 1'b0; prev_sdata = 1'b0; prev_rst = 1'b1;
        in_frame = 1'b0; have_rise = 1'b0; word = '0; want = '0;
        bits = 0; low_cyc = 0; high_cyc = 0; exp_frames = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0; have_rise = 1'b0; bits = 0; exp_frames = 0; high_cyc = 0;
            end else begin
                if (cs_n_o) check("sclk_idle_low", {31'd0, sclk_o}, 32'd0);
                if (!prev_rst && sdata_o !== prev_sdata)
                    check("sdata_change_edge",
                          32'((prev_cs && !cs_n_o) || (prev_sclk && !sclk_o)), 32'd1);
                if (prev_cs && !cs_n_o) begin
                    in_frame = 1'b1; bits = 0; word = '0; low_cyc = 0;
                    if (have_rise) gaps_q.push_back(high_cyc);
                end
                if (!cs_n_o) low_cyc++;
                if (!cs_n_o && !prev_sclk && sclk_o) begin
                    word = {word[DW-2:0], sdata_o};
                    bits++;
                end
                if (!prev_cs && cs_n_o && in_frame) begin
                    in_frame = 1'b0; have_rise = 1'b1; high_cyc = 1;
                    exp_frames++;
                    frames_done++;
                    check("frame_bits", 32'(bits), 32'(DW));
                    check("frame_len", 32'(low_cyc), 32'(FRAME));
                    check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        want = exp_q.pop_front();
                        check("frame_data", 32'(word), 32'(want));
                    end
                    check("frames_count", 32'(frames_o), 32'(exp_frames % (1 << CW)));
                    frames_log.push_back(int'(frames_o));
                end else if (cs_n_o) begin
                    high_cyc++;
                end
            end
            prev_cs = cs_n_o; prev_sclk = sclk_o; prev_sdata = sdata_o; prev_rst = rst;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        int            seq[5];
        seq = '{1, 2, 3, 0, 1};

        // Reset state
        cycle(2);
        check("rst_rd_en", {31'd0, rd_en_o}, 32'd0);
        check("rst_cs_n", {31'd0, cs_n_o}, 32'd1);
        check("rst_sclk", {31'd0, sclk_o}, 32'd0);
        check("rst_sdata", {31'd0, sdata_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_underrun", {31'd0, underrun_o}, 32'd0);
        check("rst_frames", 32'(frames_o), 32'd0);
        rst = 1'b0;
        cycle(1);

        // 1. Single sample with latency checks
        fifo_q.push_back(8'hA5);
        cycle(2);
        pops = 0;
        en_i = 1'b1;
        @(negedge clk);
        check("lat_rd_en_n", {31'd0, rd_en_o}, 32'd0);
        @(negedge clk);
        check("lat_rd_en_n1", {31'd0, rd_en_o}, 32'd1);
        @(negedge clk);
        check("lat_rd_en_n2", {31'd0, rd_en_o}, 32'd0);
        check("lat_cs_n2", {31'd0, cs_n_o}, 32'd1);
        @(negedge clk);
        check("lat_cs_n3", {31'd0, cs_n_o}, 32'd0);
        check("lat_msb_n3", {31'd0, sdata_o}, 32'd1);
        cycle(1);
        wait_frames(1, 200);
        en_i = 1'b0;
        cycle(6);
        check("t1_frames", 32'(frames_o), 32'd1);
        check("t1_pops", 32'(pops), 32'd1);
        check("t1_underrun", {31'd0, underrun_o}, 32'd0);
        check("t1_busy", {31'd0, busy_o}, 32'd0);

        // 2. Back-to-back
        do_reset();
        gaps_q.delete();
        pops = 0;
        fifo_q.push_back(8'h80);
        fifo_q.push_back(8'h7F);
        fifo_q.push_back(8'hFF);
        cycle(2);
        en_i = 1'b1;
        wait_frames(1, 200);
        check("t2_underrun_f1", {31'd0, underrun_o}, 32'd0);
        wait_frames(1, 200);
        check("t2_underrun_f2", {31'd0, underrun_o}, 32'd0);
        wait_frames(1, 200);
        cycle(8);
        check("t2_underrun_end", {31'd0, underrun_o}, 32'd1);
        check("t2_frames", 32'(frames_o), 32'd3);
        check("t2_pops", 32'(pops), 32'd3);
        check("t2_gap_count", 32'(gaps_q.size()), 32'd2);
        foreach (gaps_q[i]) check("t2_gap_len", 32'(gaps_q[i]), 32'(GAPH));
        en_i = 1'b0;

        // 3. Underrun stickiness
        do_reset();
        fifo_q.push_back(8'($urandom));
        cycle(2);
        en_i = 1'b1;
        wait_frames(1, 200);
        cycle(8);
        check("t3_underrun_set", {31'd0, underrun_o}, 32'd1);
        en_i = 1'b0;
        cycle(4);
        fifo_q.push_back(8'($urandom));
        cycle(2);
        en_i = 1'b1;
        wait_frames(1, 200);
        en_i = 1'b0;
        cycle(6);
        check("t3_underrun_sticky", {31'd0, underrun_o}, 32'd1);
        do_reset();
        check("t3_underrun_clear", {31'd0, underrun_o}, 32'd0);

        // 4. en_i drop mid-frame
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'($urandom));
        cycle(2);
        pops = 0;
        en_i = 1'b1;
        wait_cs_low(50);
        cycle(3 * 2 * CD);
        en_i = 1'b0;
        wait_frames(1, 200);
        cycle(8);
        check("t4_pops", 32'(pops), 32'd1);
        check("t4_busy", {31'd0, busy_o}, 32'd0);
        check("t4_fifo_left", 32'(fifo_q.size()), 32'd1);
        fifo_q.delete();
        cycle(2);

        // 5. Reset mid-frame
        do_reset();
        fifo_q.push_back(8'($urandom));
        cycle(2);
        en_i = 1'b1;
        wait_cs_low(50);
        cycle(5 * 2 * CD);
        do_reset();
        check("t5_cs_n", {31'd0, cs_n_o}, 32'd1);
        check("t5_sclk", {31'd0, sclk_o}, 32'd0);
        check("t5_sdata", {31'd0, sdata_o}, 32'd0);
        check("t5_frames", 32'(frames_o), 32'd0);
        check("t5_busy", {31'd0, busy_o}, 32'd0);
        w = 8'($urandom);
        fifo_q.push_back(w);
        wait_frames(1, 200);
        en_i = 1'b0;
        cycle(6);

        // 6. Frame counter wrap, random data
        do_reset();
        frames_log.delete();
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'($urandom));
        cycle(2);
        en_i = 1'b1;
        wait_frames(5, 1000);
        en_i = 1'b0;
        cycle(6);
        check("t6_log_len", 32'(frames_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < frames_log.size(); i++)
            check("t6_wrap_seq", 32'(frames_log[i]), 32'(seq[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
